// File: rtl/onehot_req_arbiter.sv
// Round-robin arbiter that turns rising edges on 16 request lines into a
// stream of strictly one-hot grants with a ready/valid handshake.
module onehot_req_arbiter #(
   parameter int N     = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     out_onehot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     pending,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int IDX_W = $clog2(N);
   localparam int POP_W = $clog2(N + 1);

   typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [N-1:0]     req_q, rise, grant, clr, drops, pending_nxt, onehot_nxt;
   logic [IDX_W-1:0] last_grant, last_nxt, grant_idx;
   logic             sel, valid_nxt;
   logic [CNT_W-1:0] drop_nxt;

   // Nearest set bit above 'last', wrapping; relies on N being a power of two.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] p,
                                                input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] idx;
      rr_pick = last;
      for (int k = N; k >= 1; k--) begin
         idx = last + IDX_W'(k);
         if (p[idx]) rr_pick = idx;
      end
   endfunction

   function automatic logic [POP_W-1:0] popcnt(input logic [N-1:0] v);
      popcnt = '0;
      for (int i = 0; i < N; i++) popcnt = popcnt + POP_W'(v[i]);
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [POP_W-1:0] b);
      logic [CNT_W:0] sum;
      sum     = {1'b0, a} + (CNT_W + 1)'(b);
      sat_add = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   assign rise = req & ~req_q;

   always_comb begin
      state_nxt  = state;
      onehot_nxt = out_onehot;
      valid_nxt  = out_valid;
      last_nxt   = last_grant;
      sel        = 1'b0;
      clr        = '0;
      grant_idx  = rr_pick(pending, last_grant);
      grant      = '0;
      grant[grant_idx] = 1'b1;

      case (state)
         IDLE: begin
            if (|pending) sel = 1'b1;
         end
         VALID: begin
            if (out_ready) begin
               if (|pending) begin
                  sel = 1'b1;
               end else begin
                  state_nxt  = IDLE;
                  onehot_nxt = '0;
                  valid_nxt  = 1'b0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (sel) begin
         state_nxt  = VALID;
         onehot_nxt = grant;
         valid_nxt  = 1'b1;
         last_nxt   = grant_idx;
         clr        = grant;
      end

      // A rise on the bit being granted re-arms it rather than counting as a drop.
      drops       = rise & pending & ~clr;
      pending_nxt = (pending & ~clr) | rise;
      drop_nxt    = sat_add(drop_cnt, popcnt(drops));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_q      <= '0;
         pending    <= '0;
         out_onehot <= '0;
         out_valid  <= 1'b0;
         drop_cnt   <= '0;
         last_grant <= IDX_W'(N - 1);
      end else begin
         state      <= state_nxt;
         req_q      <= req;
         pending    <= pending_nxt;
         out_onehot <= onehot_nxt;
         out_valid  <= valid_nxt;
         drop_cnt   <= drop_nxt;
         last_grant <= last_nxt;
      end
   end

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Directed bench for onehot_req_arbiter: an event-level model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_onehot_req_arbiter;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] out_onehot;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] pending;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // model state
   bit m_pend[16];
   bit m_req_q[16];
   bit m_valid = 0;
   int m_idx   = 0;
   int m_last  = 15;
   int m_drop  = 0;

   onehot_req_arbiter #(.N(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .out_onehot (out_onehot),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .pending    (pending),
      .drop_cnt   (drop_cnt)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_pend[i]  = 0;
         m_req_q[i] = 0;
      end
      m_valid = 0;
      m_idx   = 0;
      m_last  = 15;
      m_drop  = 0;
   endtask

   task automatic model_step();
      int sel;
      int nd;
      bit any;
      sel = -1;
      nd  = 0;
      any = 0;
      for (int i = 0; i < 16; i++) if (m_pend[i]) any = 1;
      if (any && (!m_valid || out_ready)) begin
         for (int k = 1; k <= 16; k++)
            if (sel < 0 && m_pend[(m_last + k) % 16]) sel = (m_last + k) % 16;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      for (int i = 0; i < 16; i++) begin
         if (req[i] && !m_req_q[i]) begin
            if (m_pend[i] && i != sel) nd++;
            m_pend[i] = 1;
         end else if (i == sel) begin
            m_pend[i] = 0;
         end
         m_req_q[i] = req[i];
      end
      if (sel >= 0) begin
         m_valid = 1;
         m_idx   = sel;
         m_last  = sel;
      end
      m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   logic [15:0] e_oh, e_pend;
   always @(negedge clk) begin
      if (chk_en) begin
         e_oh   = '0;
         e_pend = '0;
         if (m_valid) e_oh[m_idx] = 1'b1;
         for (int i = 0; i < 16; i++) e_pend[i] = m_pend[i];
         chk("model_onehot",  32'(out_onehot), 32'(e_oh));
         chk("model_valid",   32'(out_valid),  32'(m_valid));
         chk("model_pending", 32'(pending),    32'(e_pend));
         chk("model_drop",    32'(drop_cnt),   32'(m_drop));
         chk("popcount_inv",  32'($countones(out_onehot)), 32'(out_valid));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_onehot"},  32'(out_onehot), 32'h0);
      chk({tag, "_valid"},   32'(out_valid),  32'h0);
      chk({tag, "_pending"}, 32'(pending),    32'h0);
      chk({tag, "_drop"},    32'(drop_cnt),   32'h0);
   endtask

   task automatic do_reset();
      rst_n     = 0;
      req       = '0;
      out_ready = 0;
      tick();
      chk_zero("rst");
      rst_n = 1;
   endtask

   logic [15:0] seq2 [6] = '{16'h0000, 16'h0001, 16'h0020, 16'h0400, 16'h8000, 16'h0000};
   logic [15:0] pat4 [10] = '{16'h0000, 16'h0008, 16'h0000, 16'h0008, 16'h0008,
                              16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0008};

   initial begin
      rst_n     = 0;
      req       = '0;
      out_ready = 0;
      tick();
      tick();
      chk_en = 1;
      chk_zero("por");

      // 1: single held request
      rst_n = 1;
      req   = 16'h0001;
      tick();
      chk("t1_pending", 32'(pending), 32'h0001);
      chk("t1_valid0",  32'(out_valid), 32'h0);
      tick();
      chk("t1_onehot",  32'(out_onehot), 32'h0001);
      chk("t1_valid1",  32'(out_valid), 32'h1);
      out_ready = 1;
      tick();
      chk("t1_idle_v",  32'(out_valid), 32'h0);
      chk("t1_idle_oh", 32'(out_onehot), 32'h0);
      tick();
      chk("t1_noevt",   32'(pending), 32'h0);

      // 2: four simultaneous rises, back-to-back grants
      do_reset();
      req       = 16'h8421;
      out_ready = 1;
      tick();
      chk("t2_pending", 32'(pending), 32'h8421);
      for (int i = 1; i < 6; i++) begin
         tick();
         chk("t2_grant", 32'(out_onehot), 32'(seq2[i]));
         chk("t2_valid", 32'(out_valid), (i < 5) ? 32'h1 : 32'h0);
      end

      // 3: round-robin resumes above the last grant
      do_reset();
      req = 16'h0020;
      tick();
      tick();
      chk("t3_first", 32'(out_onehot), 32'h0020);
      req = 16'h0224;
      tick();
      chk("t3_hold",    32'(out_onehot), 32'h0020);
      chk("t3_pending", 32'(pending), 32'h0204);
      out_ready = 1;
      tick();
      chk("t3_bit9", 32'(out_onehot), 32'h0200);
      tick();
      chk("t3_bit2", 32'(out_onehot), 32'h0004);
      tick();
      chk("t3_idle", 32'(out_valid), 32'h0);

      // 4: stalled grant, repeated rises on the granted bit
      do_reset();
      req = 16'h0008;
      tick();
      tick();
      chk("t4_grant", 32'(out_onehot), 32'h0008);
      for (int i = 0; i < 10; i++) begin
         req = pat4[i];
         tick();
         chk("t4_hold_oh", 32'(out_onehot), 32'h0008);
         chk("t4_hold_v",  32'(out_valid), 32'h1);
      end
      chk("t4_pending", 32'(pending), 32'h0008);
      chk("t4_drop",    32'(drop_cnt), 32'h1);
      out_ready = 1;
      tick();
      chk("t4_regrant", 32'(out_onehot), 32'h0008);
      chk("t4_pend0",   32'(pending), 32'h0);
      tick();
      chk("t4_idle", 32'(out_valid), 32'h0);

      // 5: rise on the bit selected in the same cycle
      do_reset();
      req = 16'h0081;
      tick();
      tick();
      chk("t5_first", 32'(out_onehot), 32'h0001);
      chk("t5_pend",  32'(pending), 32'h0080);
      req = 16'h0001;
      tick();
      req       = 16'h0081;
      out_ready = 1;
      tick();
      chk("t5_sel7",    32'(out_onehot), 32'h0080);
      chk("t5_keep7",   32'(pending), 32'h0080);
      chk("t5_nodrop",  32'(drop_cnt), 32'h0);
      tick();
      chk("t5_again7",  32'(out_onehot), 32'h0080);
      chk("t5_pend0",   32'(pending), 32'h0);
      tick();
      chk("t5_idle", 32'(out_valid), 32'h0);

      // 6: drop counter saturation, then async reset mid-grant
      do_reset();
      req = 16'h0002;
      tick();
      tick();
      chk("t6_grant", 32'(out_onehot), 32'h0002);
      for (int r = 1; r <= 20; r++) begin
         req = 16'h0000;
         tick();
         req = 16'hFFFF;
         tick();
         if (r == 1)  chk("t6_drop_r1",  32'(drop_cnt), 32'd0);
         if (r == 2)  chk("t6_drop_r2",  32'(drop_cnt), 32'd16);
         if (r == 16) chk("t6_drop_r16", 32'(drop_cnt), 32'd240);
         if (r == 17) chk("t6_drop_sat", 32'(drop_cnt), 32'd255);
      end
      chk("t6_drop_hold", 32'(drop_cnt), 32'd255);
      chk("t6_still_v",   32'(out_valid), 32'h1);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk_zero("t6_async");
      tick();
      rst_n = 1;
      req   = '0;
      tick();
      chk_zero("t6_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
